wb_grf: RTL and testbench

- Writeback-side consumer of the W-stage pipeline register: takes the latched instr/pc/ALU/HILO/DM values, decodes destination and source, extracts/extends load data, and commits the result into the 32x32 general register file.
- Also serves the two D-stage read ports.
- Sits between the W pipeline register and the D-stage operand logic of the P6 five-stage MIPS core.

---
 rtl/wb_grf_if.sv | 32 +++
 rtl/wb_grf.sv | 144 ++++++++++++++
 tb/tb_wb_grf.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_grf_if.sv
// wb_grf_if: bundle between the W-stage pipeline register / D-stage operand logic and wb_grf.
//   master : drives the W-stage fields and the D-stage read addresses; receives read data
//            and the current writeback (we/addr/data) for hazard and forwarding logic.
//   slave  : the register-file side (wb_grf).
//   Signals: instr_in, pc_in, ALU_in, HILO_in, DM_in (W-stage values), ra1/ra2 (read
//            addresses), rd1/rd2 (read data), wb_we/wb_addr/wb_data (current writeback).
interface wb_grf_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      instr_in;
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] ALU_in;
    logic [WIDTH-1:0] HILO_in;
    logic [WIDTH-1:0] DM_in;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output instr_in, pc_in, ALU_in, HILO_in, DM_in, ra1, ra2,
        input  rd1, rd2, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  instr_in, pc_in, ALU_in, HILO_in, DM_in, ra1, ra2,
        output rd1, rd2, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_grf.sv
// wb_grf: writeback stage plus 32x32 general register file of the P6 MIPS core.
// Decodes the W-stage instruction into destination/source, extracts and extends load data,
// commits the result on the rising clock edge and serves two combinational D-stage reads.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset; clears every register
//   bus   - wb_grf_if.slave: W-stage inputs, read addresses/data, writeback observation
// Optional feature: define WB_GRF_BYPASS_EN to forward the value being written this cycle
// to rd1/rd2 when the read address matches the destination.
module wb_grf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);
    typedef enum logic [1:0] {SrcAlu, SrcHilo, SrcPc8, SrcLoad} src_e;

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpLhu     = 6'h25;

    logic [WIDTH-1:0] r_regs [NREG];

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic             w_dec_we;
    logic [4:0]       w_dst;
    src_e             w_src;
    logic [WIDTH-1:0] w_dm_shift;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;
    logic             w_we;
    logic [WIDTH-1:0] w_data;

    assign w_op    = bus.instr_in[31:26];
    assign w_funct = bus.instr_in[5:0];

    // Instruction decode: destination select and result source.
    always_comb begin
        w_dec_we = 1'b0;
        w_dst    = 5'd0;
        w_src    = SrcAlu;
        case (w_op)
            OpSpecial: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        w_dec_we = 1'b1;
                        w_dst    = bus.instr_in[15:11];
                        w_src    = SrcAlu;
                    end
                    6'h10, 6'h12: begin
                        w_dec_we = 1'b1;
                        w_dst    = bus.instr_in[15:11];
                        w_src    = SrcHilo;
                    end
                    6'h09: begin
                        w_dec_we = 1'b1;
                        w_dst    = bus.instr_in[15:11];
                        w_src    = SrcPc8;
                    end
                    default: ;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_dec_we = 1'b1;
                w_dst    = bus.instr_in[20:16];
                w_src    = SrcAlu;
            end
            OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
                w_dec_we = 1'b1;
                w_dst    = bus.instr_in[20:16];
                w_src    = SrcLoad;
            end
            OpJal: begin
                w_dec_we = 1'b1;
                w_dst    = 5'd31;
                w_src    = SrcPc8;
            end
            default: ;
        endcase
    end

    // Little-endian lane select; alignment is not checked, offset bits are used as given.
    assign w_dm_shift = bus.DM_in >> {bus.ALU_in[1:0], 3'b000};
    assign w_byte     = w_dm_shift[7:0];
    assign w_half     = bus.ALU_in[1] ? bus.DM_in[31:16] : bus.DM_in[15:0];

    always_comb begin
        w_load = bus.DM_in;
        case (w_op)
            OpLb:    w_load = {{(WIDTH-8){w_byte[7]}}, w_byte};
            OpLbu:   w_load = {{(WIDTH-8){1'b0}}, w_byte};
            OpLh:    w_load = {{(WIDTH-16){w_half[15]}}, w_half};
            OpLhu:   w_load = {{(WIDTH-16){1'b0}}, w_half};
            default: w_load = bus.DM_in;
        endcase
    end

    always_comb begin
        w_data = bus.ALU_in;
        case (w_src)
            SrcAlu:  w_data = bus.ALU_in;
            SrcHilo: w_data = bus.HILO_in;
            SrcPc8:  w_data = bus.pc_in + WIDTH'(8);
            SrcLoad: w_data = w_load;
            default: w_data = bus.ALU_in;
        endcase
    end

    // $0 is hard-wired: a write targeting it is suppressed entirely.
    assign w_we        = w_dec_we && (w_dst != 5'd0);
    assign bus.wb_we   = w_we;
    assign bus.wb_addr = w_we ? w_dst : 5'd0;
    assign bus.wb_data = w_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_dst] <= w_data;
        end
    end

`ifdef WB_GRF_BYPASS_EN
    // Same-cycle write-to-read forward, so W->D needs no external forwarding path.
    assign bus.rd1 = (bus.ra1 == 5'd0) ? '0 :
                     (w_we && (bus.ra1 == w_dst)) ? w_data : r_regs[bus.ra1];
    assign bus.rd2 = (bus.ra2 == 5'd0) ? '0 :
                     (w_we && (bus.ra2 == w_dst)) ? w_data : r_regs[bus.ra2];
`else
    assign bus.rd1 = (bus.ra1 == 5'd0) ? '0 : r_regs[bus.ra1];
    assign bus.rd2 = (bus.ra2 == 5'd0) ? '0 : r_regs[bus.ra2];
`endif
endmodule

// File: tb/tb_wb_grf.sv
// Directed and randomized bench for wb_grf against a mnemonic-level reference model.
module tb_wb_grf;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] model_regs [32];

    wb_grf_if #(.WIDTH(32)) bus ();

    wb_grf #(.WIDTH(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference: what an instruction writes, from its mnemonic semantics.
    function automatic void model_wb(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] alu, input logic [31:0] hilo,
                                     input logic [31:0] dm, output bit we,
                                     output logic [4:0] a, output logic [31:0] d);
        logic [5:0]  op;
        logic [5:0]  fn;
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        op  = ins[31:26];
        fn  = ins[5:0];
        off = int'(alu[1:0]);
        b   = 8'((dm >> (8 * off)) & 32'hFF);
        h   = (off >= 2) ? dm[31:16] : dm[15:0];
        we  = 1'b0;
        a   = 5'd0;
        d   = 32'd0;
        if (op == 6'h00) begin
            if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h2B,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
                we = 1'b1; a = ins[15:11]; d = alu;
            end else if (fn == 6'h10 || fn == 6'h12) begin
                we = 1'b1; a = ins[15:11]; d = hilo;
            end else if (fn == 6'h09) begin
                we = 1'b1; a = ins[15:11]; d = pc + 32'd8;
            end
        end else if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B}) begin
            we = 1'b1; a = ins[20:16]; d = alu;
        end else if (op == 6'h23) begin
            we = 1'b1; a = ins[20:16]; d = dm;
        end else if (op == 6'h20) begin
            we = 1'b1; a = ins[20:16]; d = 32'($signed(b));
        end else if (op == 6'h24) begin
            we = 1'b1; a = ins[20:16]; d = {24'd0, b};
        end else if (op == 6'h21) begin
            we = 1'b1; a = ins[20:16]; d = 32'($signed(h));
        end else if (op == 6'h25) begin
            we = 1'b1; a = ins[20:16]; d = {16'd0, h};
        end else if (op == 6'h03) begin
            we = 1'b1; a = 5'd31; d = pc + 32'd8;
        end
        if (a == 5'd0) begin
            we = 1'b0;
            a  = 5'd0;
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit we,
                                           input logic [4:0] a, input logic [31:0] d);
        if (ra == 5'd0) return 32'd0;
`ifdef WB_GRF_BYPASS_EN
        if (we && ra == a) return d;
`endif
        return model_regs[ra];
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] hilo, input logic [31:0] dm);
        @(negedge clk);
        bus.instr_in = ins;
        bus.pc_in    = pc;
        bus.ALU_in   = alu;
        bus.HILO_in  = hilo;
        bus.DM_in    = dm;
        #1;
    endtask

    // Advance one rising edge and commit the expected write into the model.
    task automatic cycle();
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
        model_wb(bus.instr_in, bus.pc_in, bus.ALU_in, bus.HILO_in, bus.DM_in, we, a, d);
        @(posedge clk);
        if (we && reset) model_regs[a] = d;
        #1;
    endtask

    task automatic check_wb(input string tag);
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
        model_wb(bus.instr_in, bus.pc_in, bus.ALU_in, bus.HILO_in, bus.DM_in, we, a, d);
        check({tag, ".we"}, {31'd0, bus.wb_we}, {31'd0, we});
        check({tag, ".addr"}, {27'd0, bus.wb_addr}, {27'd0, a});
        if (we) check({tag, ".data"}, bus.wb_data, d);
        check({tag, ".rd1"}, bus.rd1, exp_rd(bus.ra1, we, a, d));
        check({tag, ".rd2"}, bus.rd2, exp_rd(bus.ra2, we, a, d));
    endtask

    initial begin
        bit [11:0] kinds [40] = '{
            {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h27},
            {6'h00, 6'h26}, {6'h00, 6'h2A}, {6'h00, 6'h2B}, {6'h00, 6'h00}, {6'h00, 6'h02},
            {6'h00, 6'h03}, {6'h00, 6'h04}, {6'h00, 6'h06}, {6'h00, 6'h07}, {6'h00, 6'h10},
            {6'h00, 6'h12}, {6'h00, 6'h09}, {6'h00, 6'h08}, {6'h00, 6'h18}, {6'h00, 6'h11},
            {6'h00, 6'h1A}, {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00},
            {6'h0E, 6'h00}, {6'h0F, 6'h00}, {6'h0A, 6'h00}, {6'h0B, 6'h00}, {6'h20, 6'h00},
            {6'h21, 6'h00}, {6'h23, 6'h00}, {6'h24, 6'h00}, {6'h25, 6'h00}, {6'h03, 6'h00},
            {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h05, 6'h00}, {6'h28, 6'h00}};
        logic [31:0] ins;
        logic [5:0]  op;

        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset        = 1'b0;
        bus.instr_in = 32'd0;
        bus.pc_in    = 32'd0;
        bus.ALU_in   = 32'd0;
        bus.HILO_in  = 32'd0;
        bus.DM_in    = 32'd0;
        bus.ra1      = 5'd0;
        bus.ra2      = 5'd0;

        // Reset, release, every index reads zero.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i);
            bus.ra2 = 5'(31 - i);
            #1;
            check("reset.rd1", bus.rd1, 32'd0);
            check("reset.rd2", bus.rd2, 32'd0);
        end

        // ori $5,$0,0x1234
        drive(32'h3405_1234, 32'h0, 32'h0000_1234, 32'h0, 32'h0);
        check("ori.we", {31'd0, bus.wb_we}, 32'd1);
        check("ori.addr", {27'd0, bus.wb_addr}, 32'd5);
        check("ori.data", bus.wb_data, 32'h0000_1234);
        cycle();
        bus.ra1 = 5'd5;
        #1;
        check("ori.read", bus.rd1, 32'h0000_1234);

        // Load extension corners.
        drive(32'h8006_0001, 32'h0, 32'h1, 32'h0, 32'h12F4_5678);
        check("lb.pos", bus.wb_data, 32'h0000_0056);
        drive(32'h8006_0001, 32'h0, 32'h1, 32'h0, 32'h1234_F678);
        check("lb.neg", bus.wb_data, 32'hFFFF_FFF6);
        drive(32'h9006_0001, 32'h0, 32'h1, 32'h0, 32'h1234_F678);
        check("lbu", bus.wb_data, 32'h0000_00F6);
        drive(32'h8406_0002, 32'h0, 32'h2, 32'h0, 32'h8001_0000);
        check("lh.hi", bus.wb_data, 32'hFFFF_8001);
        check("lh.addr", {27'd0, bus.wb_addr}, 32'd6);
        cycle();

        // jal, then a write aimed at $0.
        drive(32'h0C00_0000, 32'h0000_3000, 32'h0, 32'h0, 32'h0);
        check("jal.addr", {27'd0, bus.wb_addr}, 32'd31);
        check("jal.data", bus.wb_data, 32'h0000_3008);
        cycle();
        drive(32'h0022_0021, 32'h0, 32'hAAAA_5555, 32'h0, 32'h0);
        check("addu0.we", {31'd0, bus.wb_we}, 32'd0);
        check("addu0.addr", {27'd0, bus.wb_addr}, 32'd0);
        cycle();
        bus.ra1 = 5'd0;
        #1;
        check("r0.read", bus.rd1, 32'd0);

        // Write $7 with its old value present, read it in the same cycle.
        drive(32'h0000_3821, 32'h0, 32'h1111_1111, 32'h0, 32'h0);
        cycle();
        drive(32'h0000_3821, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        bus.ra1 = 5'd7;
        #1;
`ifdef WB_GRF_BYPASS_EN
        check("same.before", bus.rd1, 32'hDEAD_BEEF);
`else
        check("same.before", bus.rd1, 32'h1111_1111);
`endif
        cycle();
        check("same.after", bus.rd1, 32'hDEAD_BEEF);

        // Stores and branches change nothing.
        drive(32'hAC07_0000, 32'h0, 32'h0000_0040, 32'h0, 32'h5555_5555);
        check("sw.we", {31'd0, bus.wb_we}, 32'd0);
        cycle();
        drive(32'h10E7_0004, 32'h0, 32'h0, 32'h0, 32'h0);
        check("beq.we", {31'd0, bus.wb_we}, 32'd0);
        cycle();
        check("sw_beq.r7", bus.rd1, 32'hDEAD_BEEF);

        // Reset mid-cycle while a write to $9 is pending.
        drive(32'h3409_0077, 32'h0, 32'h0000_0077, 32'h0, 32'h0);
        cycle();
        bus.ra1 = 5'd9;
        #1;
        check("r9.pre", bus.rd1, 32'h0000_0077);
        drive(32'h3409_00AA, 32'h0, 32'h0000_00AA, 32'h0, 32'h0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        #1;
        check("rst.we", {31'd0, bus.wb_we}, 32'd1);
        check("rst.rd", bus.rd1, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        bus.instr_in = 32'd0;
        #1;
        check("rst.r9", bus.rd1, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int k;
            k   = int'($urandom_range(0, 39));
            op  = kinds[k][11:6];
            ins = {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   (op == 6'h00) ? kinds[k][5:0] : 6'($urandom)};
            drive(ins, $urandom, $urandom, $urandom, $urandom);
            bus.ra1 = 5'($urandom);
            bus.ra2 = 5'($urandom);
            #1;
            check_wb("rand");
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
